// File: rtl/cnt_btn_if.sv
// Raw push-button inputs and the rate-controlled SS/MODE/RUN outputs of the
// counter front end, bundled so the driver side and the block share one port.
interface cnt_btn_if;
  logic BTN_SS;
  logic BTN_MODE;
  logic SS;
  logic MODE;
  logic RUN;

  modport master (output BTN_SS, BTN_MODE, input SS, MODE, RUN);
  modport slave  (input BTN_SS, BTN_MODE, output SS, MODE, RUN);
endinterface

// File: rtl/cnt_btn_ctrl.sv
// Button conditioning (sync + debounce) and run/direction toggles feeding a
// prescaler that emits one-cycle SS pulses at a fixed rate while running.

// Per-button lane: 2-flop synchroniser and a hold-time debouncer that flags
// the edge on which a 0->1 change is accepted.
module cnt_btn_deb #(
  parameter int DEB_N = 16,
  parameter int CW    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);
  logic          r_s1, r_s2, r_db;
  logic [CW-1:0] r_cnt;
  logic          w_hit;

  assign w_hit   = (r_s2 != r_db) && (r_cnt == CW'(DEB_N - 1));
  assign o_press = w_hit && r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_db)
        r_cnt <= '0;
      else if (w_hit) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else
        r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

module cnt_btn_ctrl #(
  parameter int DEB_N  = 16,
  parameter int TICK_N = 1000,
  parameter int CW     = 16
) (
  input  logic      clk,
  input  logic      rst,
  cnt_btn_if.slave  bus
);
  localparam int NUM_BTN = 2;
  localparam int B_SS    = 0;
  localparam int B_MODE  = 1;

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} run_st_t;

  logic [NUM_BTN-1:0] w_raw, w_press;
  run_st_t            r_st, w_st_nxt;
  logic               w_run;
  logic               r_mode, r_ss;
  logic [CW-1:0]      r_pre;

  assign w_raw = {bus.BTN_MODE, bus.BTN_SS};

  cnt_btn_deb #(.DEB_N(DEB_N), .CW(CW)) u_deb [NUM_BTN-1:0] (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (w_raw),
    .o_press (w_press)
  );

  always_ff @(posedge clk) begin
    if (rst) r_st <= ST_STOP;
    else     r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    if (w_press[B_SS])
      w_st_nxt = (r_st == ST_RUN) ? ST_STOP : ST_RUN;
  end

  always_comb begin
    w_run = (r_st == ST_RUN);
  end

  // Direction is free-running w.r.t. the prescaler: no reset of pre on toggle.
  always_ff @(posedge clk) begin
    if (rst)                 r_mode <= 1'b1;
    else if (w_press[B_MODE]) r_mode <= ~r_mode;
  end

  // Prescaler looks at RUN before any same-edge toggle, so a stop discards
  // the pending tick and a restart always begins from pre=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_ss  <= 1'b0;
    end else if (!w_run) begin
      r_pre <= '0;
      r_ss  <= 1'b0;
    end else if (r_pre == CW'(TICK_N - 1)) begin
      r_pre <= '0;
      r_ss  <= 1'b1;
    end else begin
      r_pre <= r_pre + CW'(1);
      r_ss  <= 1'b0;
    end
  end

  assign bus.SS   = r_ss;
  assign bus.MODE = r_mode;
  assign bus.RUN  = w_run;
endmodule

// File: tb/tb_cnt_btn_ctrl.sv
// Bench for cnt_btn_ctrl: directed scenarios plus random bouncing buttons,
// all checked against a window/arithmetic reference model.
module tb_cnt_btn_ctrl;
  localparam int DEB_N  = 4;
  localparam int TICK_N = 5;
  localparam int CW     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cnt_btn_if bif();

  cnt_btn_ctrl #(.DEB_N(DEB_N), .TICK_N(TICK_N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: raw samples delayed two edges give the synchronised
  // level; a button is accepted once the last DEB_N synchronised levels all
  // differ from the accepted level. SS is pure arithmetic on the rise edge.
  int edge_n = 0;
  bit m_ss, m_mode, m_run;
  int m_rise;
  bit rawh [2][2];
  bit win  [2][DEB_N];
  int wfill[2];
  bit m_db [2];

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      rawh[b][0] = 0; rawh[b][1] = 0;
      for (int i = 0; i < DEB_N; i++) win[b][i] = 0;
      wfill[b] = 0;
      m_db[b]  = 0;
    end
    m_run = 0; m_mode = 1; m_ss = 0; m_rise = 0;
  endtask

  task automatic step();
    bit raw[2];
    bit pr[2];
    bit s2, all;
    @(posedge clk);
    edge_n++;
    raw[0] = bif.BTN_SS;
    raw[1] = bif.BTN_MODE;
    if (rst) model_reset();
    else begin
      for (int b = 0; b < 2; b++) begin
        s2 = rawh[b][1];
        rawh[b][1] = rawh[b][0];
        rawh[b][0] = raw[b];
        for (int i = 0; i < DEB_N - 1; i++) win[b][i] = win[b][i+1];
        win[b][DEB_N-1] = s2;
        if (wfill[b] < DEB_N) wfill[b]++;
        all = 1;
        for (int i = 0; i < DEB_N; i++) if (win[b][i] == m_db[b]) all = 0;
        pr[b] = 0;
        if (wfill[b] == DEB_N && all) begin
          m_db[b] = s2;
          pr[b]   = s2;
        end
      end
      m_ss = m_run && (((edge_n - m_rise) % TICK_N) == 0);
      if (pr[0]) begin
        m_run = !m_run;
        if (m_run) m_rise = edge_n;
      end
      if (pr[1]) m_mode = !m_mode;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) step();
    rst = 0;
  endtask

  task automatic test_reset();
    bit exp_run;
    bif.BTN_SS = 1; bif.BTN_MODE = 1; rst = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      nchk++;
      if (bif.SS !== 1'b0 || bif.MODE !== 1'b1 || bif.RUN !== 1'b0) begin
        nerr++;
        $display("FAIL reset_vals: SS/MODE/RUN got %b%b%b want 010", bif.SS, bif.MODE, bif.RUN);
      end
    end
    rst = 0;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_run = (e >= DEB_N + 2);
      nchk++;
      if (bif.RUN !== exp_run) begin
        nerr++;
        $display("FAIL reset_held_run e=%0d: RUN got %b want %b", e, bif.RUN, exp_run);
      end
    end
    bif.BTN_SS = 0; bif.BTN_MODE = 0;
    for (int e = 0; e < 8; e++) begin
      step();
      nchk++;
      if ({bif.SS, bif.MODE, bif.RUN} !== {m_ss, m_mode, m_run}) begin
        nerr++;
        $display("FAIL reset_model e=%0d: SS/MODE/RUN got %b%b%b want %b%b%b", e, bif.SS, bif.MODE, bif.RUN, m_ss, m_mode, m_run);
      end
    end
  endtask

  task automatic test_clean_press();
    bit exp_run, exp_ss;
    do_reset(2);
    bif.BTN_SS = 1;
    for (int e = 1; e <= 25; e++) begin
      step();
      if (e == 10) bif.BTN_SS = 0;
      exp_run = (e >= 6);
      exp_ss  = (e >= 11) && ((e - 11) % 5 == 0);
      nchk++;
      if (bif.RUN !== exp_run || bif.SS !== exp_ss) begin
        nerr++;
        $display("FAIL clean_press e=%0d: RUN/SS got %b%b want %b%b", e, bif.RUN, bif.SS, exp_run, exp_ss);
      end
      nchk++;
      if ({bif.SS, bif.MODE, bif.RUN} !== {m_ss, m_mode, m_run}) begin
        nerr++;
        $display("FAIL clean_model e=%0d: SS/MODE/RUN got %b%b%b want %b%b%b", e, bif.SS, bif.MODE, bif.RUN, m_ss, m_mode, m_run);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat[28];
    bit prev;
    int toggles;
    pat = '{1,1,1,0,1,1,1,0,0,0,0,0, 1,1,1,1,1,1, 0,0,0,0,0,0,0,0,0,0};
    do_reset(2);
    prev = 0; toggles = 0;
    for (int e = 0; e < 28; e++) begin
      bif.BTN_SS = pat[e];
      step();
      if (bif.RUN !== prev) toggles++;
      prev = bif.RUN;
      if (e < 14) begin
        nchk++;
        if (bif.RUN !== 1'b0) begin
          nerr++;
          $display("FAIL bounce_reject e=%0d: RUN got %b want 0", e, bif.RUN);
        end
      end
      nchk++;
      if ({bif.SS, bif.MODE, bif.RUN} !== {m_ss, m_mode, m_run}) begin
        nerr++;
        $display("FAIL bounce_model e=%0d: SS/MODE/RUN got %b%b%b want %b%b%b", e, bif.SS, bif.MODE, bif.RUN, m_ss, m_mode, m_run);
      end
    end
    nchk++;
    if (toggles != 1 || bif.RUN !== 1'b1) begin
      nerr++;
      $display("FAIL bounce_toggles: toggles %0d RUN %b want 1 and 1", toggles, bif.RUN);
    end
  endtask

  task automatic test_dir_change();
    int cb;
    bit exp_ss;
    cb = 12 + int'($urandom_range(0, 4));
    do_reset(2);
    bif.BTN_SS = 1;
    for (int e = 1; e <= 45; e++) begin
      if (e == 9)      bif.BTN_SS = 0;
      if (e == cb)     bif.BTN_MODE = 1;
      if (e == cb + 8) bif.BTN_MODE = 0;
      step();
      exp_ss = (e >= 11) && ((e - 11) % 5 == 0);
      nchk++;
      if (bif.SS !== exp_ss) begin
        nerr++;
        $display("FAIL dir_cadence e=%0d: SS got %b want %b", e, bif.SS, exp_ss);
      end
      if (e == cb + 4 || e == cb + 5) begin
        nchk++;
        if (bif.MODE !== (e == cb + 4)) begin
          nerr++;
          $display("FAIL dir_mode e=%0d: MODE got %b want %b", e, bif.MODE, (e == cb + 4));
        end
      end
      nchk++;
      if ({bif.SS, bif.MODE, bif.RUN} !== {m_ss, m_mode, m_run}) begin
        nerr++;
        $display("FAIL dir_model e=%0d: SS/MODE/RUN got %b%b%b want %b%b%b", e, bif.SS, bif.MODE, bif.RUN, m_ss, m_mode, m_run);
      end
    end
  endtask

  task automatic test_stop_restart();
    bit exp_run, exp_ss;
    do_reset(2);
    for (int e = 1; e <= 55; e++) begin
      bif.BTN_SS = (e <= 8) || (e >= 15 && e <= 22) || (e >= 35 && e <= 42);
      step();
      exp_run = (e >= 6 && e < 20) || (e >= 40);
      exp_ss  = (e == 11) || (e == 16) || (e == 45) || (e == 50) || (e == 55);
      nchk++;
      if (bif.RUN !== exp_run || bif.SS !== exp_ss) begin
        nerr++;
        $display("FAIL stop_restart e=%0d: RUN/SS got %b%b want %b%b", e, bif.RUN, bif.SS, exp_run, exp_ss);
      end
      nchk++;
      if ({bif.SS, bif.MODE, bif.RUN} !== {m_ss, m_mode, m_run}) begin
        nerr++;
        $display("FAIL stop_model e=%0d: SS/MODE/RUN got %b%b%b want %b%b%b", e, bif.SS, bif.MODE, bif.RUN, m_ss, m_mode, m_run);
      end
    end
    bif.BTN_SS = 0;
  endtask

  task automatic test_simultaneous();
    do_reset(2);
    for (int e = 1; e <= 13; e++) begin
      bif.BTN_SS   = (e <= 8);
      bif.BTN_MODE = (e <= 8);
      step();
      nchk++;
      if (bif.RUN !== (e >= 6) || bif.MODE !== (e < 6)) begin
        nerr++;
        $display("FAIL simul_toggle e=%0d: RUN/MODE got %b%b want %b%b", e, bif.RUN, bif.MODE, (e >= 6), (e < 6));
      end
    end
    rst = 1;
    step();
    nchk++;
    if (bif.SS !== 1'b0 || bif.MODE !== 1'b1 || bif.RUN !== 1'b0) begin
      nerr++;
      $display("FAIL midrun_reset: SS/MODE/RUN got %b%b%b want 010", bif.SS, bif.MODE, bif.RUN);
    end
    rst = 0;
  endtask

  task automatic test_random();
    int hold[2];
    hold[0] = 0; hold[1] = 0;
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      if (hold[0] == 0) begin bif.BTN_SS   = 1'($urandom_range(0, 1)); hold[0] = $urandom_range(1, 12); end
      if (hold[1] == 0) begin bif.BTN_MODE = 1'($urandom_range(0, 1)); hold[1] = $urandom_range(1, 12); end
      hold[0]--; hold[1]--;
      rst = ($urandom_range(0, 399) == 0);
      step();
      nchk++;
      if ({bif.SS, bif.MODE, bif.RUN} !== {m_ss, m_mode, m_run}) begin
        nerr++;
        $display("FAIL random_model c=%0d: SS/MODE/RUN got %b%b%b want %b%b%b", c, bif.SS, bif.MODE, bif.RUN, m_ss, m_mode, m_run);
      end
    end
    rst = 0;
  endtask

  initial begin
    bif.BTN_SS = 0;
    bif.BTN_MODE = 0;
    rst = 1;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_dir_change();
    test_stop_restart();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
